psum_accumulator: RTL and testbench

- Output-side accumulation stage for one systolic-array column; one instance per column.
- Consumes per-row partial sums streaming out of the array's bottom adder chain.
- Accumulates them across K-tiles in a DEPTH-entry buffer indexed by row.
- On the last K-tile, emits final sums through a valid/ready port to the writeback/requantize stage.

---
 rtl/acc_pkg.sv | 26 ++
 rtl/psum_sat_add.sv | 34 +++
 rtl/psum_accumulator.sv | 97 +++++++++
 tb/tb_psum_accumulator.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared constants and helpers for the partial-sum accumulation path.
// Helpers operate on a fixed 64-bit carrier; callers cast down to their own width.
package acc_pkg;

    localparam int IN_WIDTH_DEFAULT  = 32;
    localparam int ACC_WIDTH_DEFAULT = 40;
    localparam int MAX_W             = 64;

    // Replicates bit (w-1) of v into every higher bit of the 64-bit carrier.
    function automatic logic [MAX_W-1:0] sign_extend(input logic [MAX_W-1:0] v, input int w);
        logic [MAX_W-1:0] r;
        r = v;
        for (int i = 0; i < MAX_W; i++) begin
            if (i >= w) r[i] = v[w-1];
        end
        return r;
    endfunction

    // Largest positive (neg=0) or most negative (neg=1) value of a w-bit signed number.
    function automatic logic [MAX_W-1:0] sat_limit(input int w, input logic neg);
        logic [MAX_W-1:0] m;
        m = (MAX_W'(1) << (w - 1)) - MAX_W'(1);
        return neg ? ~m : m;
    endfunction

endpackage

// File: rtl/psum_sat_add.sv
// Combinational signed accumulate of a narrow partial sum into a wide accumulator,
// with optional clamping to the accumulator's signed range.
module psum_sat_add
    import acc_pkg::*;
#(
    parameter int    IN_WIDTH  = IN_WIDTH_DEFAULT,
    parameter int    ACC_WIDTH = ACC_WIDTH_DEFAULT,
    parameter string SATURATE  = "FALSE"
) (
    input  logic [ACC_WIDTH-1:0] acc_i,
    input  logic [IN_WIDTH-1:0]  in_i,
    output logic [ACC_WIDTH-1:0] sum_o,
    output logic                 sat_o
);

    localparam bit                   DO_SAT  = (SATURATE == "TRUE");
    localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(sat_limit(ACC_WIDTH, 1'b0));
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(sat_limit(ACC_WIDTH, 1'b1));

    logic [ACC_WIDTH-1:0] ext;
    logic [ACC_WIDTH-1:0] raw;
    logic                 ovf;

    // Overflow is only possible when both operands share a sign the result lacks.
    always_comb begin
        ext   = ACC_WIDTH'(sign_extend(MAX_W'(in_i), IN_WIDTH));
        raw   = acc_i + ext;
        ovf   = (acc_i[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) && (raw[ACC_WIDTH-1] != acc_i[ACC_WIDTH-1]);
        sat_o = DO_SAT && ovf;
        sum_o = raw;
        if (sat_o) sum_o = acc_i[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX;
    end

endmodule

// File: rtl/psum_accumulator.sv
// Per-column accumulator: sums row partial sums across K-tiles and emits the
// final row sums through a single-entry valid/ready output register.
module psum_accumulator
    import acc_pkg::*;
#(
    parameter int    IN_WIDTH   = IN_WIDTH_DEFAULT,
    parameter int    ACC_WIDTH  = ACC_WIDTH_DEFAULT,
    parameter int    DEPTH      = 16,
    parameter int    ADDR_WIDTH = 4,
    parameter string SATURATE   = "FALSE"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_first,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic [ADDR_WIDTH-1:0] row_idx,
    output logic                  tile_done,
    output logic                  sat_flag
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(DEPTH - 1);

    logic [ACC_WIDTH-1:0]  buf_q [DEPTH];
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic                  out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0]  out_data_q, out_data_d;
    logic                  tile_done_q, tile_done_d;
    logic                  sat_q, sat_d;

    logic                  accept;
    logic [ACC_WIDTH-1:0]  acc_sel;
    logic [ACC_WIDTH-1:0]  sum;
    logic                  sat_hit;

    psum_sat_add #(
        .IN_WIDTH  (IN_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .SATURATE  (SATURATE)
    ) u_add (
        .acc_i (acc_sel),
        .in_i  (in_data),
        .sum_o (sum),
        .sat_o (sat_hit)
    );

    // A full output register blocks every input, last-tile or not, so results stay in row order.
    always_comb begin
        in_ready    = !out_valid_q || out_ready;
        accept      = in_valid && in_ready;
        acc_sel     = in_first ? '0 : buf_q[row_q];
        row_d       = accept ? row_q + ADDR_WIDTH'(1) : row_q;
        tile_done_d = accept && (row_q == LAST_ROW);
        sat_d       = sat_q || (accept && sat_hit);
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept && in_last) begin
            out_valid_d = 1'b1;
            out_data_d  = sum;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            tile_done_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            tile_done_q <= tile_done_d;
            sat_q       <= sat_d;
        end
    end

    // No reset on the buffer: every tile starts with in_first, which overwrites the entry.
    always_ff @(posedge clk) begin
        if (accept && !in_last) buf_q[row_q] <= sum;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign row_idx   = row_q;
    assign tile_done = tile_done_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench: a saturating and a wrapping instance share one stimulus stream
// and are each checked against a longint behavioural model.
module tb_psum_accumulator;

    localparam longint SAT_MAX = 64'sd549755813887;
    localparam longint SAT_MIN = -64'sd549755813888;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inValid = 1'b0;
    logic        inFirst = 1'b0;
    logic        inLast = 1'b0;
    logic        outReady = 1'b0;
    logic [31:0] inData = '0;

    logic        satInReady, satOutValid, satTileDone, satSatFlag;
    logic [39:0] satOutData;
    logic [1:0]  satRowIdx;
    logic        wrapInReady, wrapOutValid, wrapTileDone, wrapSatFlag;
    logic [39:0] wrapOutData;
    logic [1:0]  wrapRowIdx;

    int checks = 0;
    int failures = 0;

    logic [39:0] satQ[$];
    logic [39:0] wrapQ[$];
    longint      satBuf[4];
    longint      wrapBuf[4];
    int          modelRow = 0;
    bit          tileDoneExp = 1'b0;
    bit          satFlagExp = 1'b0;
    longint      xIn, sSum, wSum;

    always #5 clk = ~clk;

    psum_accumulator #(
        .IN_WIDTH(32), .ACC_WIDTH(40), .DEPTH(4), .ADDR_WIDTH(2), .SATURATE("TRUE")
    ) dutSat (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(satInReady),
        .in_data(inData), .in_first(inFirst), .in_last(inLast),
        .out_valid(satOutValid), .out_ready(outReady), .out_data(satOutData),
        .row_idx(satRowIdx), .tile_done(satTileDone), .sat_flag(satSatFlag)
    );

    psum_accumulator #(
        .IN_WIDTH(32), .ACC_WIDTH(40), .DEPTH(4), .ADDR_WIDTH(2), .SATURATE("FALSE")
    ) dutWrap (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(wrapInReady),
        .in_data(inData), .in_first(inFirst), .in_last(inLast),
        .out_valid(wrapOutValid), .out_ready(outReady), .out_data(wrapOutData),
        .row_idx(wrapRowIdx), .tile_done(wrapTileDone), .sat_flag(wrapSatFlag)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic longint wrap40(input longint v);
        logic [39:0] t;
        t = v[39:0];
        return longint'($signed(t));
    endfunction

    // Behavioural model, evaluated with pre-edge values at each rising edge.
    always @(posedge clk) begin
        if (!reset && inValid && satInReady) begin
            xIn  = longint'($signed(inData));
            sSum = inFirst ? xIn : satBuf[modelRow] + xIn;
            if (sSum > SAT_MAX) begin
                sSum = SAT_MAX;
                satFlagExp = 1'b1;
            end else if (sSum < SAT_MIN) begin
                sSum = SAT_MIN;
                satFlagExp = 1'b1;
            end
            wSum = wrap40(inFirst ? xIn : wrapBuf[modelRow] + xIn);
            if (inLast) begin
                satQ.push_back(sSum[39:0]);
                wrapQ.push_back(wSum[39:0]);
            end else begin
                satBuf[modelRow]  = sSum;
                wrapBuf[modelRow] = wSum;
            end
            tileDoneExp = (modelRow == 3);
            modelRow = (modelRow + 1) % 4;
        end else begin
            tileDoneExp = 1'b0;
        end
    end

    // Output monitor away from the active edge; pops when a handshake will complete.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("sat_out_valid", 64'(satOutValid), 64'(satQ.size() != 0));
            checkOutput("wrap_out_valid", 64'(wrapOutValid), 64'(wrapQ.size() != 0));
            if (satOutValid && satQ.size() != 0) begin
                checkOutput("sat_out_data", 64'(satOutData), 64'(satQ[0]));
                if (outReady) void'(satQ.pop_front());
            end
            if (wrapOutValid && wrapQ.size() != 0) begin
                checkOutput("wrap_out_data", 64'(wrapOutData), 64'(wrapQ[0]));
                if (outReady) void'(wrapQ.pop_front());
            end
            checkOutput("row_idx", 64'(satRowIdx), 64'(modelRow));
            checkOutput("wrap_row_idx", 64'(wrapRowIdx), 64'(modelRow));
            checkOutput("tile_done", 64'(satTileDone), 64'(tileDoneExp));
            checkOutput("wrap_tile_done", 64'(wrapTileDone), 64'(tileDoneExp));
            checkOutput("sat_flag", 64'(satSatFlag), 64'(satFlagExp));
            checkOutput("wrap_sat_flag", 64'(wrapSatFlag), 64'd0);
        end
    end

    task automatic applyStimulus(input logic [31:0] d, input bit f, input bit l);
        bit accepted;
        int waitCycles;
        accepted = 1'b0;
        waitCycles = 0;
        inValid = 1'b1;
        inData  = d;
        inFirst = f;
        inLast  = l;
        while (!accepted && waitCycles < 50) begin
            @(negedge clk);
            accepted = satInReady;
            @(posedge clk);
            #1;
            waitCycles++;
        end
        if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
        inValid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearModel();
        satQ.delete();
        wrapQ.delete();
        modelRow = 0;
        tileDoneExp = 1'b0;
        satFlagExp = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int t0[4];
        int t1[4];
        int t2[4];
        logic [31:0] v;
        t0 = '{10, 20, 30, 40};
        t1 = '{-4, -5, -6, -7};
        t2 = '{100, 200, 300, 400};

        idleCycles(3);
        @(negedge clk);
        checkOutput("rst_row_idx", 64'(satRowIdx), 64'd0);
        checkOutput("rst_out_valid", 64'(satOutValid), 64'd0);
        checkOutput("rst_out_data", 64'(satOutData), 64'd0);
        checkOutput("rst_tile_done", 64'(satTileDone), 64'd0);
        checkOutput("rst_sat_flag", 64'(satSatFlag), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        outReady = 1'b1;

        // Single K-tile, back-to-back results.
        applyStimulus(32'd5, 1, 1);
        applyStimulus(-32'sd3, 1, 1);
        applyStimulus(32'd7, 1, 1);
        applyStimulus(32'd0, 1, 1);
        idleCycles(2);

        // Three K-tiles; row_idx wraps twice before the last tile.
        for (int r = 0; r < 4; r++) applyStimulus(t0[r], 1, 0);
        for (int r = 0; r < 4; r++) applyStimulus(t1[r], 0, 0);
        for (int r = 0; r < 4; r++) applyStimulus(t2[r], 0, 1);
        idleCycles(2);

        // Back-pressure with the first result held for three cycles.
        for (int r = 0; r < 4; r++) applyStimulus(t0[r], 1, 0);
        for (int r = 0; r < 4; r++) applyStimulus(t1[r], 0, 0);
        outReady = 1'b0;
        applyStimulus(t2[0], 0, 1);
        inValid = 1'b1;
        inData  = t2[1];
        inFirst = 1'b0;
        inLast  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 64'(satInReady), 64'd0);
            checkOutput("bp_hold", 64'(satOutData), 64'd106);
            @(posedge clk);
            #1;
        end
        outReady = 1'b1;
        applyStimulus(t2[1], 0, 1);
        applyStimulus(t2[2], 0, 1);
        applyStimulus(t2[3], 0, 1);
        idleCycles(2);

        // Sign extension of -1.
        applyStimulus(32'hFFFF_FFFF, 1, 1);
        @(negedge clk);
        checkOutput("sext", 64'(satOutData), 64'hFF_FFFF_FFFF);
        @(posedge clk);
        #1;
        for (int r = 1; r < 4; r++) applyStimulus(32'd0, 1, 1);
        idleCycles(2);

        // Build row 0 up to 2^39-1, then add 1 on the last tile.
        for (int t = 0; t < 258; t++) begin
            for (int r = 0; r < 4; r++) begin
                if (r != 0) v = 32'd0;
                else if (t < 256) v = 32'h7FFF_FFFF;
                else if (t == 256) v = 32'h0000_00FF;
                else v = 32'd1;
                applyStimulus(v, t == 0, t == 257);
                if (t == 257 && r == 0) begin
                    @(negedge clk);
                    checkOutput("sat_clamp", 64'(satOutData), 64'h7F_FFFF_FFFF);
                    checkOutput("wrap_result", 64'(wrapOutData), 64'h80_0000_0000);
                    checkOutput("sat_flag_set", 64'(satSatFlag), 64'd1);
                    checkOutput("wrap_flag_zero", 64'(wrapSatFlag), 64'd0);
                    @(posedge clk);
                    #1;
                end
            end
        end
        idleCycles(2);

        // Reset while a result is in flight during the second K-tile.
        for (int r = 0; r < 4; r++) applyStimulus(r + 1, 1, 0);
        applyStimulus(32'd50, 0, 0);
        applyStimulus(32'd60, 0, 0);
        outReady = 1'b0;
        applyStimulus(32'd70, 0, 1);
        #2;
        reset = 1'b1;
        clearModel();
        #1;
        checkOutput("async_out_valid", 64'(satOutValid), 64'd0);
        checkOutput("async_row_idx", 64'(satRowIdx), 64'd0);
        checkOutput("async_out_data", 64'(satOutData), 64'd0);
        checkOutput("async_sat_flag", 64'(satSatFlag), 64'd0);
        idleCycles(2);
        reset = 1'b0;
        outReady = 1'b1;
        applyStimulus(32'd9, 1, 0);
        applyStimulus(-32'sd9, 1, 0);
        applyStimulus(32'd11, 1, 0);
        applyStimulus(32'd12, 1, 0);
        applyStimulus(32'd1, 0, 1);
        @(negedge clk);
        checkOutput("post_rst_row0", 64'(satOutData), 64'd10);
        @(posedge clk);
        #1;
        applyStimulus(32'd1, 0, 1);
        applyStimulus(32'd1, 0, 1);
        applyStimulus(32'd1, 0, 1);
        idleCycles(3);

        checkOutput("drain_sat", 64'(satQ.size()), 64'd0);
        checkOutput("drain_wrap", 64'(wrapQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
